uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver (8N1, LSB first) that converts the line input into the byte stream feeding the rxbyte port of the framing block. It oversamples the line with an integer baud divider, rejects glitch start bits, and flags framing and overrun errors. Output is a single-entry AXI4-Stream register, with no tlast.

## Interface
- BAUD_DIV, 868: clock cycles per bit (100 MHz / 115200); legal range 4..65535.
- aclk  in  1  system clock; all logic on rising edge.
- areset  in  1  reset; one clock; reset is synchronous and active-high.
- rx  in  1  asynchronous serial line; idle high.
- rxbyte_tvalid  out  1  received byte available.
- rxbyte_tready  in  1  downstream accepts byte.
- rxbyte_tdata  out  8  received byte.
- frame_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun_error  out  1  one-cycle pulse: byte completed while output register still full.

## Operation
- rx passes through a 2-flop synchronizer (both flops reset to 1). The synchronizer output is rx_s.
- Bit counter is $clog2(BAUD_DIV) bits wide and counts down. HALF = BAUD_DIV/2 (floor).
- FSM states: IDLE, START, DATA, STOP, BREAK. Reset state is IDLE.
- IDLE: when rx_s == 0, go to START and load counter for HALF.
- START: at the sample point, if rx_s == 1 (glitch), go to IDLE with no output and no error. Otherwise go to DATA, bit index 0, and load BAUD_DIV.
- DATA: at each sample point, shift rx_s into bit[index]; LSB is received first. After index 7, go to STOP and load BAUD_DIV.
- STOP: at the sample point:
  - rx_s == 1: deliver the byte, then go to IDLE.
  - rx_s == 0: pulse frame_error, discard the byte, go to BREAK.
- BREAK: remain until rx_s == 1, then go to IDLE. This prevents a held-low line from being read as repeated bytes.
- Delivery:
  - If rxbyte_tvalid == 0, or a handshake occurs in the same cycle: load tdata and set tvalid.
  - Otherwise: drop the new byte, keep the held byte, and pulse overrun_error.
- AXI rules:
  - tvalid drops only after a handshake (tvalid && tready).
  - tdata is stable while tvalid is high and tready is low.
  - tvalid does not depend combinationally on tready.
- Reset values: rxbyte_tvalid = 0, rxbyte_tdata = 0x00, frame_error = 0, overrun_error = 0, shift register = 0, counter = 0.
- Reset mid-byte aborts the byte with no output and no error; the next detected start bit begins a fresh byte.

## Timing
- Synchronizer latency: 2 cycles from the rx pin to rx_s.
- Let cycle 0 be the first IDLE cycle in which rx_s == 0. Sample points, relative to cycle 0:
  - start bit at HALF;
  - data bit i at HALF + (i+1)*BAUD_DIV;
  - stop bit at HALF + 9*BAUD_DIV.
- rxbyte_tvalid (or the frame_error pulse) is registered and asserts on cycle HALF + 9*BAUD_DIV + 1.
- After a good stop sample, IDLE is re-entered half a bit early. A start edge arriving right at the end of the stop bit is caught, so back-to-back bytes need no idle gap.
- Error pulses are exactly 1 cycle wide. frame_error and overrun_error never assert in the same cycle; framing-errored bytes are not delivered.
- A simultaneous handshake and delivery in one cycle loads the new byte with no bubble; tvalid stays high.
- Tolerance: cumulative baud mismatch up to ±4% over 10 bits is sampled correctly for BAUD_DIV ≥ 16.

## Test plan
- Single byte: BAUD_DIV=16, tready=1, send 0xA5 8N1.
  - tvalid high for exactly 1 cycle with tdata=0xA5.
  - tvalid rises 2 + 8 + 144 + 1 = 155 cycles after the pin falling edge.
- Back-to-back: send 0x7D, 0x7E, 0x7F with no idle gap, tready=1.
  - Three handshakes with values in order; no errors.
- Glitch: drive rx low for 3 cycles, then high, at BAUD_DIV=16.
  - No tvalid, no frame_error; FSM back in IDLE.
  - A following 0x3C is received correctly.
- Framing error: send 0x55 with stop bit 0, hold the line low for 40 bits, then release and send 0x3C.
  - One frame_error pulse only; 0x55 is never presented.
  - Next handshake carries 0x3C.
- Overrun: tready=0, send 0x11 then 0x22.
  - tdata holds 0x11 throughout; one overrun_error pulse at the 0x22 stop sample.
  - Raise tready: one handshake with 0x11, then tvalid=0.
- Reset mid-byte: assert areset for 1 cycle during data bit 4 of 0x99, then send 0x42.
  - All outputs 0 after the reset cycle; no output for 0x99.
  - Next byte delivered is 0x42.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte stream from the serial receiver to the framing block.
// AXI4-Stream subset: single byte per beat, no tlast.
interface uart_rx_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first, with glitch-start rejection and framing/overrun flags.
// The received byte is held in a single-entry stream register until the consumer takes it.
module uart_rx #(
    parameter int BAUD_DIV = 868
) (
    input  logic      aclk,
    input  logic      areset,
    input  logic      rx,
    uart_rx_if.master rxbyte,
    output logic      frame_error,
    output logic      overrun_error
);

    localparam int              CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tvalid_q;
    logic [7:0]       tdata_q;

    logic             sample;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             shift_en;
    logic             byte_done;
    logic             stop_bad;

    assign rxbyte.tvalid = tvalid_q;
    assign rxbyte.tdata  = tdata_q;
    assign sample        = (cnt == '0);

    // Idle-high line, so the synchronizer comes out of reset as "idle".
    always_ff @(posedge aclk) begin
        if (areset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = BIT_LOAD;
        shift_en     = 1'b0;
        byte_done    = 1'b0;
        stop_bad     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next   = START;
                    cnt_load     = 1'b1;
                    cnt_load_val = HALF_LOAD;
                end
            end
            START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_load   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_en = 1'b1;
                    cnt_load = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Returning to IDLE at mid-stop lets a back-to-back start edge be caught.
                if (sample) begin
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (cnt_load) begin
                cnt <= cnt_load_val;
            end else if (!sample) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx        <= bit_idx + 3'd1;
                shift[bit_idx] <= rx_s;
            end
        end
    end

    // A completed byte only replaces the held one if the slot is empty or draining this cycle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tvalid_q      <= 1'b0;
            tdata_q       <= 8'h00;
            frame_error   <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            frame_error   <= stop_bad;
            overrun_error <= 1'b0;
            if (byte_done && (!tvalid_q || rxbyte.tready)) begin
                tvalid_q <= 1'b1;
                tdata_q  <= shift;
            end else begin
                if (tvalid_q && rxbyte.tready) begin
                    tvalid_q <= 1'b0;
                end
                if (byte_done) begin
                    overrun_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=16: a table of single frames plus
// hand-written sequences for latency, back-to-back, glitch, break, overrun and reset.
module tb_uart_rx;

    localparam int BD = 16;

    logic aclk;
    logic areset;
    logic rx;
    logic frame_error;
    logic overrun_error;

    uart_rx_if rxb ();

    uart_rx #(.BAUD_DIV(BD)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .rx            (rx),
        .rxbyte        (rxb),
        .frame_error   (frame_error),
        .overrun_error (overrun_error)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int         valid_cycles  = 0;
    int         last_rise_cyc = -1;
    int         ferr_count    = 0;
    int         oerr_count    = 0;
    int         last_oerr_cyc = -1;
    int         both_err      = 0;
    int         stab_err      = 0;
    logic [7:0] hs_log[$];

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    // Observes the stream and error pulses once per cycle, away from the active edge.
    initial begin
        logic       prev_valid;
        logic       prev_ready;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge aclk);
            if (rxb.tvalid) valid_cycles++;
            if (rxb.tvalid && !prev_valid) last_rise_cyc = cyc;
            if (rxb.tvalid && rxb.tready) hs_log.push_back(rxb.tdata);
            if (frame_error) ferr_count++;
            if (overrun_error) begin
                oerr_count++;
                last_oerr_cyc = cyc;
            end
            if (frame_error && overrun_error) both_err++;
            if (!areset && prev_valid && !prev_ready && (!rxb.tvalid || rxb.tdata != prev_data))
                stab_err++;
            prev_valid = rxb.tvalid;
            prev_ready = rxb.tready;
            prev_data  = rxb.tdata;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int lastByte();
        if (hs_log.size() == 0) return -1;
        return int'(hs_log[hs_log.size() - 1]);
    endfunction

    // Sends one frame; start bit begins just after the next clock edge. Returns on the
    // edge before the frame's end so a following call continues with no gap.
    // abort_bit >= 0 pulses reset mid-way through that data bit and abandons the frame.
    task automatic applyStimulus(input logic [7:0] d, input logic stop_bit,
                                 input int abort_bit, output int t0);
        @(posedge aclk);
        #1;
        t0 = cyc;
        rx = 1'b0;
        repeat (BD) @(posedge aclk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            if (i == abort_bit) begin
                repeat (BD / 2) @(posedge aclk);
                #1 areset = 1'b1;
                @(posedge aclk);
                #1 areset = 1'b0;
                rx = 1'b1;
                return;
            end
            repeat (BD) @(posedge aclk);
        end
        #1 rx = stop_bit;
        repeat (BD - 1) @(posedge aclk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_hs;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t0;
        int t1;
        int hs0;
        int vc0;
        int fe0;
        int oe0;

        vecs[0] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[2] = '{8'h01, 1'b1, 1, 8'h01, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 8'h80, 0};
        vecs[4] = '{8'hC3, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'h5A, 1'b1, 1, 8'h5A, 0};

        rx = 1'b1;
        areset = 1'b1;
        rxb.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        checkOutput("reset tvalid", int'(rxb.tvalid), 0);
        checkOutput("reset tdata", int'(rxb.tdata), 0);
        checkOutput("reset frame_error", int'(frame_error), 0);
        checkOutput("reset overrun_error", int'(overrun_error), 0);
        idle(10);

        $display("[TB] single byte 0xA5 with latency");
        hs0 = hs_log.size();
        vc0 = valid_cycles;
        applyStimulus(8'hA5, 1'b1, -1, t0);
        idle(20);
        checkOutput("A5 latency", last_rise_cyc - t0, 155);
        checkOutput("A5 valid width", valid_cycles - vc0, 1);
        checkOutput("A5 handshakes", hs_log.size() - hs0, 1);
        checkOutput("A5 data", lastByte(), 8'hA5);

        $display("[TB] table vectors");
        for (int v = 0; v < 6; v++) begin
            hs0 = hs_log.size();
            fe0 = ferr_count;
            oe0 = oerr_count;
            applyStimulus(vecs[v].data, vecs[v].stop_bit, -1, t0);
            @(posedge aclk);
            #1 rx = 1'b1;
            idle(24);
            checkOutput($sformatf("vec%0d handshakes", v), hs_log.size() - hs0, vecs[v].exp_hs);
            checkOutput($sformatf("vec%0d frame_error", v), ferr_count - fe0, vecs[v].exp_ferr);
            checkOutput($sformatf("vec%0d overrun", v), oerr_count - oe0, 0);
            if (vecs[v].exp_hs > 0)
                checkOutput($sformatf("vec%0d data", v), lastByte(), int'(vecs[v].exp_data));
        end

        $display("[TB] back-to-back 7D 7E 7F");
        hs0 = hs_log.size();
        fe0 = ferr_count;
        oe0 = oerr_count;
        applyStimulus(8'h7D, 1'b1, -1, t0);
        applyStimulus(8'h7E, 1'b1, -1, t0);
        applyStimulus(8'h7F, 1'b1, -1, t0);
        idle(24);
        checkOutput("b2b handshakes", hs_log.size() - hs0, 3);
        if (hs_log.size() - hs0 == 3) begin
            checkOutput("b2b byte0", int'(hs_log[hs0]), 8'h7D);
            checkOutput("b2b byte1", int'(hs_log[hs0 + 1]), 8'h7E);
            checkOutput("b2b byte2", int'(hs_log[hs0 + 2]), 8'h7F);
        end
        checkOutput("b2b errors", (ferr_count - fe0) + (oerr_count - oe0), 0);

        $display("[TB] glitch start bit");
        hs0 = hs_log.size();
        vc0 = valid_cycles;
        fe0 = ferr_count;
        @(posedge aclk);
        #1 rx = 1'b0;
        repeat (3) @(posedge aclk);
        #1 rx = 1'b1;
        idle(40);
        checkOutput("glitch valid", valid_cycles - vc0, 0);
        checkOutput("glitch frame_error", ferr_count - fe0, 0);
        applyStimulus(8'h3C, 1'b1, -1, t0);
        idle(24);
        checkOutput("glitch follow-up handshakes", hs_log.size() - hs0, 1);
        checkOutput("glitch follow-up data", lastByte(), 8'h3C);

        $display("[TB] framing error and held break");
        hs0 = hs_log.size();
        vc0 = valid_cycles;
        fe0 = ferr_count;
        applyStimulus(8'h55, 1'b0, -1, t0);
        repeat (40 * BD) @(posedge aclk);
        #1 rx = 1'b1;
        idle(32);
        applyStimulus(8'h3C, 1'b1, -1, t0);
        idle(24);
        checkOutput("break frame_error", ferr_count - fe0, 1);
        checkOutput("break valid cycles", valid_cycles - vc0, 1);
        checkOutput("break handshakes", hs_log.size() - hs0, 1);
        checkOutput("break next data", lastByte(), 8'h3C);

        $display("[TB] overrun");
        rxb.tready = 1'b0;
        hs0 = hs_log.size();
        oe0 = oerr_count;
        applyStimulus(8'h11, 1'b1, -1, t0);
        applyStimulus(8'h22, 1'b1, -1, t1);
        idle(24);
        @(negedge aclk);
        checkOutput("overrun tvalid held", int'(rxb.tvalid), 1);
        checkOutput("overrun tdata held", int'(rxb.tdata), 8'h11);
        checkOutput("overrun pulses", oerr_count - oe0, 1);
        checkOutput("overrun pulse cycle", last_oerr_cyc - t1, 155);
        checkOutput("overrun no handshake", hs_log.size() - hs0, 0);
        @(posedge aclk);
        #1 rxb.tready = 1'b1;
        idle(5);
        @(negedge aclk);
        checkOutput("overrun drain handshakes", hs_log.size() - hs0, 1);
        checkOutput("overrun drain data", lastByte(), 8'h11);
        checkOutput("overrun drain tvalid", int'(rxb.tvalid), 0);

        $display("[TB] reset mid-byte");
        hs0 = hs_log.size();
        vc0 = valid_cycles;
        fe0 = ferr_count;
        applyStimulus(8'h99, 1'b1, 4, t0);
        @(negedge aclk);
        checkOutput("midreset tvalid", int'(rxb.tvalid), 0);
        checkOutput("midreset tdata", int'(rxb.tdata), 0);
        checkOutput("midreset frame_error", int'(frame_error), 0);
        checkOutput("midreset overrun_error", int'(overrun_error), 0);
        idle(BD * 12);
        checkOutput("midreset no output", valid_cycles - vc0, 0);
        checkOutput("midreset no error", ferr_count - fe0, 0);
        applyStimulus(8'h42, 1'b1, -1, t0);
        idle(24);
        checkOutput("midreset next handshakes", hs_log.size() - hs0, 1);
        checkOutput("midreset next data", lastByte(), 8'h42);

        checkOutput("errors same cycle", both_err, 0);
        checkOutput("tdata/tvalid stability", stab_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
